// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_pkg
// Description : Shared definitions for the fb_cpu memory side: instruction
//               opcodes, I/O window offsets relative to IO_BASE and the
//               bus responder state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

    // Instruction opcodes
    localparam int OP_LOD = 0;
    localparam int OP_STO = 1;
    localparam int OP_ADD = 2;
    localparam int OP_SUB = 3;
    localparam int OP_MUL = 4;
    localparam int OP_DIV = 5;
    localparam int OP_JMP = 6;
    localparam int OP_JMZ = 7;
    localparam int OP_NOP = 8;
    localparam int OP_HLT = 9;

    // I/O register offsets from IO_BASE
    localparam int IO_SW     = 0;
    localparam int IO_LED_LO = 1;
    localparam int IO_LED_HI = 2;
    localparam int IO_SEG    = 3;

    // Bus responder state
    typedef enum logic [0:0] {
        LOAD = 1'b0,
        RUN  = 1'b1
    } resp_state_t;

endpackage
`default_nettype wire

// File: rtl/fb_ram_sp.sv
`default_nettype none
// ============================================================================
// Module      : fb_ram_sp
// Description : Single-port synchronous RAM, registered read, read-before-
//               write (a read and write of the same word in one cycle returns
//               the previous contents). Contents are never reset.
// Ports       : clk   - clock
//               we    - write enable
//               addr  - word address
//               wdata - write data
//               rdata - registered read data (1-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
module fb_ram_sp #(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 10,
    parameter int DEPTH         = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        rdata <= r_mem[addr];
    end

endmodule
`default_nettype wire

// File: rtl/fb_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : fb_bus_responder
// Description : Memory-side responder for the fb_cpu RAM bus. Serves CPU
//               reads/writes from internal RAM plus a 4-register I/O window
//               at IO_BASE (switches, LED low/high, seven-segment), and owns
//               program loading: after reset it accepts words on the load
//               port while holding the CPU in reset, then releases it.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               i_addr/i_we/i_wdata - CPU bus request (MAR/RAMWr/MDRin)
//               o_rdata             - registered read data (MDROut)
//               i_ld_valid/i_ld_data/i_ld_last/o_ld_ready - program load port
//               o_cpu_rst           - reset to fb_cpu, high while loading
//               i_switches          - board switches
//               o_leds, o_seg_val   - LED and seven-segment registers
//               o_wp_fault          - sticky write-protect violation flag
// Option      : FB_BUS_WRITE_PROTECT_EN - in RUN, drop bus writes to RAM
//               below the load count and raise o_wp_fault.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_bus_responder
    import fb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 10,
    parameter int DEPTH         = 64,
    parameter int IO_BASE       = 60
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] i_addr,
    input  logic                     i_we,
    input  logic [DATA_WIDTH-1:0]    i_wdata,
    output logic [DATA_WIDTH-1:0]    o_rdata,
    input  logic                     i_ld_valid,
    input  logic [DATA_WIDTH-1:0]    i_ld_data,
    input  logic                     i_ld_last,
    output logic                     o_ld_ready,
    output logic                     o_cpu_rst,
    input  logic [15:0]              i_switches,
    output logic [15:0]              o_leds,
    output logic [DATA_WIDTH-1:0]    o_seg_val,
    output logic                     o_wp_fault
);

    resp_state_t              r_state;
    logic [ADDRESS_WIDTH-1:0] r_ld_ptr;
    logic                     r_ld_ready;
    logic                     r_cpu_rst;
    logic [15:0]              r_leds;
    logic [DATA_WIDTH-1:0]    r_seg;
    logic                     r_sel_ram;
    logic [DATA_WIDTH-1:0]    r_io_q;

    logic                     w_run;
    logic                     w_ld_accept;
    logic                     w_ld_done;
    logic                     w_is_ram;
    logic                     w_is_io;
    logic [ADDRESS_WIDTH-1:0] w_io_off;
    logic                     w_bus_we_ram;
    logic                     w_io_we;
    logic                     w_wp_hit;
    logic [DATA_WIDTH-1:0]    w_io_rd;
    logic                     w_ram_we;
    logic [ADDRESS_WIDTH-1:0] w_ram_addr;
    logic [DATA_WIDTH-1:0]    w_ram_wdata;
    logic [DATA_WIDTH-1:0]    w_ram_q;
    logic                     w_unused_sw;

    assign w_run       = (r_state == RUN);
    // Ready is always high in LOAD, so valid alone qualifies an accept there.
    assign w_ld_accept = !w_run && i_ld_valid;
    assign w_ld_done   = w_ld_accept &&
                         (i_ld_last || (r_ld_ptr == ADDRESS_WIDTH'(DEPTH - 1)));

    assign w_is_ram     = (i_addr < ADDRESS_WIDTH'(IO_BASE));
    assign w_io_off     = i_addr - ADDRESS_WIDTH'(IO_BASE);
    assign w_is_io      = !w_is_ram && (w_io_off < ADDRESS_WIDTH'(4));
    assign w_bus_we_ram = w_run && i_we && w_is_ram;
    assign w_io_we      = w_run && i_we && w_is_io;

    // The single RAM port belongs to the loader in LOAD and to the CPU in RUN.
    assign w_ram_we    = w_run ? (w_bus_we_ram && !w_wp_hit) : w_ld_accept;
    assign w_ram_addr  = w_run ? i_addr  : r_ld_ptr;
    assign w_ram_wdata = w_run ? i_wdata : i_ld_data;

    assign w_unused_sw = ^i_switches[15:10];

`ifdef FB_BUS_WRITE_PROTECT_EN
    logic [ADDRESS_WIDTH:0] r_ld_count;
    logic                   r_wp_fault;

    assign w_wp_hit   = w_bus_we_ram && ({1'b0, i_addr} < r_ld_count);
    assign o_wp_fault = r_wp_fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ld_count <= '0;
            r_wp_fault <= 1'b0;
        end else begin
            if (w_ld_accept) begin
                r_ld_count <= r_ld_count + 1'b1;
            end
            if (w_wp_hit) begin
                r_wp_fault <= 1'b1;
            end
        end
    end
`else
    assign w_wp_hit   = 1'b0;
    assign o_wp_fault = 1'b0;
`endif

    // Loader FSM; outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= LOAD;
            r_ld_ptr   <= '0;
            r_ld_ready <= 1'b1;
            r_cpu_rst  <= 1'b1;
        end else if (r_state == LOAD) begin
            if (w_ld_accept) begin
                r_ld_ptr <= r_ld_ptr + 1'b1;
                if (w_ld_done) begin
                    r_state    <= RUN;
                    r_ld_ready <= 1'b0;
                    r_cpu_rst  <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_io_rd = '0;
        if (w_is_io) begin
            case (w_io_off)
                ADDRESS_WIDTH'(IO_SW):     w_io_rd = DATA_WIDTH'(i_switches[9:0]);
                ADDRESS_WIDTH'(IO_LED_LO): w_io_rd = DATA_WIDTH'(r_leds[9:0]);
                ADDRESS_WIDTH'(IO_LED_HI): w_io_rd = DATA_WIDTH'(r_leds[15:10]);
                ADDRESS_WIDTH'(IO_SEG):    w_io_rd = r_seg;
                default:                   w_io_rd = '0;
            endcase
        end
    end

    // I/O registers and read-source tracking. The RAM read is already
    // registered, so only the source select and I/O value are flopped here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_leds    <= '0;
            r_seg     <= '0;
            r_sel_ram <= 1'b0;
            r_io_q    <= '0;
        end else begin
            r_sel_ram <= w_run && w_is_ram;
            r_io_q    <= w_run ? w_io_rd : '0;
            if (w_io_we) begin
                case (w_io_off)
                    ADDRESS_WIDTH'(IO_LED_LO): r_leds[9:0]   <= 10'(i_wdata);
                    ADDRESS_WIDTH'(IO_LED_HI): r_leds[15:10] <= 6'(i_wdata);
                    ADDRESS_WIDTH'(IO_SEG):    r_seg         <= i_wdata;
                    default: ;
                endcase
            end
        end
    end

    fb_ram_sp #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .DEPTH         (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (w_ram_wdata),
        .rdata (w_ram_q)
    );

    assign o_rdata    = r_sel_ram ? w_ram_q : r_io_q;
    assign o_ld_ready = r_ld_ready;
    assign o_cpu_rst  = r_cpu_rst;
    assign o_leds     = r_leds;
    assign o_seg_val  = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_fb_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_bus_responder
// Description : Self-checking bench for fb_bus_responder. Drives directed and
//               $urandom stimulus one cycle at a time and compares every
//               registered output against a behavioural model of the memory
//               map and loader held in plain arrays and variables.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_bus_responder;

    localparam int AW      = 6;
    localparam int DW      = 10;
    localparam int DEPTH   = 64;
    localparam int IO_BASE = 60;
`ifdef FB_BUS_WRITE_PROTECT_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] i_addr;
    logic          i_we;
    logic [DW-1:0] i_wdata;
    logic [DW-1:0] o_rdata;
    logic          i_ld_valid;
    logic [DW-1:0] i_ld_data;
    logic          i_ld_last;
    logic          o_ld_ready;
    logic          o_cpu_rst;
    logic [15:0]   i_switches;
    logic [15:0]   o_leds;
    logic [DW-1:0] o_seg_val;
    logic          o_wp_fault;

    always #5 clk = ~clk;

    fb_bus_responder #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .DEPTH         (DEPTH),
        .IO_BASE       (IO_BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_addr     (i_addr),
        .i_we       (i_we),
        .i_wdata    (i_wdata),
        .o_rdata    (o_rdata),
        .i_ld_valid (i_ld_valid),
        .i_ld_data  (i_ld_data),
        .i_ld_last  (i_ld_last),
        .o_ld_ready (o_ld_ready),
        .o_cpu_rst  (o_cpu_rst),
        .i_switches (i_switches),
        .o_leds     (o_leds),
        .o_seg_val  (o_seg_val),
        .o_wp_fault (o_wp_fault)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_vld [DEPTH];
    bit            m_run;
    int            m_ptr;
    int            m_cnt;
    logic [15:0]   m_leds;
    logic [DW-1:0] m_seg;
    bit            m_fault;
    logic [DW-1:0] m_rdata;
    bit            m_rknown;

    // Apply one clock of stimulus, advance the model, then compare outputs.
    task automatic cycle(input bit r, input bit ldv, input bit ldl, input logic [DW-1:0] ldd,
                         input int addr, input bit we, input logic [DW-1:0] wd,
                         input logic [15:0] sw);
        rst        = r;
        i_ld_valid = ldv;
        i_ld_last  = ldl;
        i_ld_data  = ldd;
        i_addr     = AW'(addr);
        i_we       = we;
        i_wdata    = wd;
        i_switches = sw;

        if (r) begin
            m_run = 0; m_ptr = 0; m_cnt = 0;
            m_leds = '0; m_seg = '0; m_fault = 0;
            m_rdata = '0; m_rknown = 1;
        end else if (!m_run) begin
            m_rdata = '0; m_rknown = 1;
            if (ldv) begin
                m_mem[m_ptr] = ldd;
                m_vld[m_ptr] = 1;
                if (ldl || m_ptr == DEPTH - 1) m_run = 1;
                m_ptr++;
                m_cnt++;
            end
        end else begin
            m_rknown = 1;
            if (addr < IO_BASE) begin
                m_rdata  = m_mem[addr];
                m_rknown = m_vld[addr];
            end else if (addr == IO_BASE)     m_rdata = sw[9:0];
            else if (addr == IO_BASE + 1)     m_rdata = m_leds[9:0];
            else if (addr == IO_BASE + 2)     m_rdata = {4'b0, m_leds[15:10]};
            else                              m_rdata = m_seg;
            if (we) begin
                if (addr < IO_BASE) begin
                    if (WP && addr < m_cnt) m_fault = 1;
                    else begin m_mem[addr] = wd; m_vld[addr] = 1; end
                end
                else if (addr == IO_BASE + 1) m_leds[9:0]   = wd;
                else if (addr == IO_BASE + 2) m_leds[15:10] = wd[5:0];
                else if (addr == IO_BASE + 3) m_seg         = wd;
            end
        end

        @(posedge clk);
        #1;
        check_eq("ld_ready", 32'(o_ld_ready), 32'(!m_run));
        check_eq("cpu_rst",  32'(o_cpu_rst),  32'(!m_run));
        check_eq("leds",     32'(o_leds),     32'(m_leds));
        check_eq("seg_val",  32'(o_seg_val),  32'(m_seg));
        check_eq("wp_fault", 32'(o_wp_fault), 32'(m_fault));
        if (m_rknown) check_eq("rdata", 32'(o_rdata), 32'(m_rdata));
    endtask

    task automatic idle_ld(input bit ldv, input bit ldl, input logic [DW-1:0] ldd);
        cycle(0, ldv, ldl, ldd, 0, 0, '0, 16'h0);
    endtask

    task automatic bus(input int addr, input bit we, input logic [DW-1:0] wd, input logic [15:0] sw);
        cycle(0, 0, 0, '0, addr, we, wd, sw);
    endtask

    logic [DW-1:0] prog [4];

    initial begin
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
        prog[0] = 10'h032; prog[1] = 10'h0B3; prog[2] = 10'h074; prog[3] = 10'h240;

        // Reset
        cycle(1, 0, 0, '0, 0, 0, '0, 16'h0);
        cycle(1, 1, 0, 10'h3FF, 5, 1, 10'h3FF, 16'hFFFF);
        check_eq("rst_rdata", 32'(o_rdata), 32'h0);

        // Directed load of four words, last on the fourth
        for (int i = 0; i < 4; i++) idle_ld(1, i == 3, prog[i]);
        check_eq("ready_after_last", 32'(o_ld_ready), 32'h0);
        idle_ld(1, 0, 10'h3CC); // ignored in RUN

        // RAM[0..3] and 1-cycle read latency
        for (int i = 0; i < 4; i++) begin
            bus(i, 0, '0, 16'h0);
            check_eq("ram_prog", 32'(o_rdata), 32'(prog[i]));
        end
        bus(2, 0, '0, 16'h0);
        check_eq("rd_a2", 32'(o_rdata), 32'h074);

        // Read-before-write at address 40
        bus(40, 1, 10'h0AA, 16'h0);
        bus(40, 1, 10'h155, 16'h0);
        check_eq("rbw_old", 32'(o_rdata), 32'h0AA);
        bus(40, 0, '0, 16'h0);
        check_eq("rbw_new", 32'(o_rdata), 32'h155);

        // I/O window
        bus(IO_BASE + 1, 1, 10'h3FF, 16'h0);
        bus(IO_BASE + 2, 1, 10'h02A, 16'h0);
        check_eq("leds_abff", 32'(o_leds), 32'hABFF);
        bus(IO_BASE, 0, '0, 16'h1234);
        check_eq("sw_read", 32'(o_rdata), 32'h234);
        bus(IO_BASE + 3, 1, 10'h005, 16'h0);
        check_eq("seg_5", 32'(o_seg_val), 32'h5);
        bus(IO_BASE, 1, 10'h3FF, 16'h0);
        bus(IO_BASE + 2, 0, '0, 16'h0);
        check_eq("led_hi_read", 32'(o_rdata), 32'h02A);

        // Write-protect region (behaviour depends on the build option)
        bus(2, 1, 10'h3AB, 16'h0);
        bus(2, 0, '0, 16'h0);
        check_eq("wp_a2", 32'(o_rdata), WP ? 32'h074 : 32'h3AB);
        check_eq("wp_flag", 32'(o_wp_fault), 32'(WP));
        bus(52, 1, 10'h1C7, 16'h0);
        bus(52, 0, '0, 16'h0);
        check_eq("wr_a52", 32'(o_rdata), 32'h1C7);

        // Random bus traffic in RUN
        for (int i = 0; i < 300; i++)
            bus($urandom_range(0, DEPTH - 1), 1'($urandom), DW'($urandom), 16'($urandom));

        // Reset after two of four words: loader restarts at address 0
        cycle(1, 0, 0, '0, 0, 0, '0, 16'h0);
        idle_ld(1, 0, 10'h101);
        idle_ld(1, 0, 10'h102);
        cycle(1, 0, 0, '0, 0, 0, '0, 16'h0);
        check_eq("midrst_cpu_rst", 32'(o_cpu_rst), 32'h1);
        idle_ld(1, 0, 10'h1A0);
        idle_ld(0, 0, 10'h3FF);
        idle_ld(1, 0, 10'h1A1);
        idle_ld(1, 0, 10'h1A2);
        check_eq("midrst_still_loading", 32'(o_cpu_rst), 32'h1);
        idle_ld(1, 1, 10'h1A3);
        bus(0, 0, '0, 16'h0);
        check_eq("midrst_a0", 32'(o_rdata), 32'h1A0);

        // Full-depth load without last: ends when the final address is taken
        cycle(1, 0, 0, '0, 0, 0, '0, 16'h0);
        for (int i = 0; i < DEPTH; i++) begin
            if ($urandom_range(0, 3) == 0) idle_ld(0, 0, DW'($urandom));
            idle_ld(1, 0, DW'($urandom));
        end
        check_eq("full_load_run", 32'(o_cpu_rst), 32'h0);
        for (int i = 0; i < 150; i++)
            bus($urandom_range(0, DEPTH - 1), 1'($urandom), DW'($urandom), 16'($urandom));

        // Mixed random: occasional resets, random loads and bus traffic
        cycle(1, 0, 0, '0, 0, 0, '0, 16'h0);
        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 99) == 0, 1'($urandom), $urandom_range(0, 7) == 0,
                  DW'($urandom), $urandom_range(0, DEPTH - 1), 1'($urandom),
                  DW'($urandom), 16'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fb_bus_responder.md
Name: fb_bus_responder

Overview:
- Memory-side responder for the fb_cpu RAM bus: serves the CPU's MAR/RAMWr/MDRin/MDROut transactions from internal RAM plus a small memory-mapped I/O window.
- Also owns program loading: after reset it accepts program words on a valid/ready load port while holding the CPU in reset, then releases it.
- Sits in top between fb_cpu, the switch/LED/seven-segment pins and an external program source, replacing the fixed-init blram.

Parameters:
- ADDRESS_WIDTH, 6, bus address width.
- DATA_WIDTH, 10, bus data width.
- DEPTH, 64, RAM words; must equal 2**ADDRESS_WIDTH.
- IO_BASE, 60, first I/O address; IO_BASE..IO_BASE+3 are I/O, and IO_BASE+3 must be at most DEPTH-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_addr  in  ADDRESS_WIDTH  bus address (CPU MAR).
- i_we  in  1  bus write enable (CPU RAMWr).
- i_wdata  in  DATA_WIDTH  bus write data (CPU MDRin).
- o_rdata  out  DATA_WIDTH  registered read data (CPU MDROut).
- i_ld_valid  in  1  load word valid.
- i_ld_data  in  DATA_WIDTH  load word.
- i_ld_last  in  1  marks final load word; qualified by i_ld_valid.
- o_ld_ready  out  1  load port ready.
- o_cpu_rst  out  1  reset to fb_cpu.
- i_switches  in  16  board switches.
- o_leds  out  16  LED register.
- o_seg_val  out  DATA_WIDTH  seven-segment value register.
- o_wp_fault  out  1  sticky write-protect violation flag.

Behaviour:
- Reset is decided as follows: reset rst, synchronous, active-high; clock clk.
- Reset values: o_rdata=0, o_ld_ready=1, o_cpu_rst=1, o_leds=0, o_seg_val=0, o_wp_fault=0.
- Reset effect on internal state: state=LOAD, load pointer=0, load count=0. RAM contents are not cleared.
- FSM state LOAD:
  - o_ld_ready=1, o_cpu_rst=1; bus inputs are ignored and o_rdata is held at 0.
  - Each i_ld_valid&o_ld_ready cycle writes mem[ptr]=i_ld_data, then ptr++ and count++.
  - Transition to RUN when the accepted word has i_ld_last=1, or when ptr==DEPTH-1 is accepted (no wrap).
  - In RUN: o_ld_ready=0 from the next cycle. o_cpu_rst deasserts on the first RUN cycle, one cycle after the last accept.
- FSM state RUN:
  - No exit except rst. i_ld_valid is ignored.
- Read path: o_rdata updates on the clock edge after i_addr is presented, i.e. 1-cycle latency, every cycle.
- Write path: takes effect on the clock edge where i_we=1.
- Read and write to the same address in the same cycle returns the old value (read-before-write).
- Address map for addresses below IO_BASE: RAM read/write.
- Address map for the I/O window:
  - IO_BASE: read i_switches[9:0]; writes ignored.
  - IO_BASE+1: o_leds[9:0], read/write.
  - IO_BASE+2: o_leds[15:10] in bits [5:0], read/write; upper bits read as 0 and are ignored on write.
  - IO_BASE+3: o_seg_val, read/write.
- I/O writes never modify RAM. RAM cells at IO_BASE and above are reachable only via the load port.
- A reset asserted mid-load or mid-run aborts immediately. The loader restarts at address 0 and words already written remain in RAM.

Optional Feature:
- Macro FB_BUS_WRITE_PROTECT_EN.
- When defined, in RUN, a bus write to a RAM address below the load count is dropped. o_wp_fault is set and stays high until rst. I/O writes are unaffected.
- When undefined, all RAM writes proceed and o_wp_fault is tied 0.

Decomposition:
- Shared package fb_pkg holds:
  - opcode constants (LOD=0, STO=1, ADD=2, SUB=3, MUL=4, DIV=5, JMP=6, JMZ=7, NOP=8, HLT=9);
  - the IO_BASE offset constants (SW=0, LED_LO=1, LED_HI=2, SEG=3);
  - the responder state enum (LOAD, RUN).
- One sub-module: fb_ram_sp, a single-port synchronous RAM with registered read-before-write.
- The address decode, I/O registers and FSM stay in fb_bus_responder.

Test Plan:
- Load 0x032, 0x0B3, 0x074, 0x240 with last on the 4th word:
  - o_ld_ready drops after the 4th accept;
  - o_cpu_rst falls one cycle later;
  - RAM[0..3] matches.
- In RUN, i_addr=2: o_rdata=0x074 exactly one cycle later. Same-cycle write 0x155 to addr 40 plus read of addr 40 returns the old value, and 0x155 on the next read.
- Write 0x3FF to IO_BASE+1, then 0x2A to IO_BASE+2 → o_leds=0xABFF. i_switches=0x1234, read IO_BASE → 0x234.
- Write 0x005 to IO_BASE+3 → o_seg_val=5. Write to IO_BASE → no change anywhere.
- Assert rst after 2 of 4 load words: o_cpu_rst stays 1 and the next accepted word lands at address 0.
- With FB_BUS_WRITE_PROTECT_EN and load count 4:
  - write to addr 2 → RAM[2] unchanged, o_wp_fault=1;
  - write to addr 52 succeeds.
